// File: rtl/cic_dec_prog.sv
// Runtime-programmable CIC decimator: N integrators on the qualified input stream,
// N combs at the decimated rate, round-half-up scaling and saturation to COUT bits.
module cic_dec_prog #(
  parameter int RMAX = 256,
  parameter int M    = 2,
  parameter int N    = 3,
  parameter int BIN  = 16,
  parameter int COUT = 16,
  localparam int BOUT = BIN + N * $clog2(RMAX * M),
  localparam int RW   = $clog2(RMAX) + 1,
  localparam int SW   = $clog2(BOUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [RW-1:0]          cfg_rate,
  input  logic [SW-1:0]          cfg_shift,
  output logic                   cfg_err,
  input  logic                   din_vld,
  input  logic signed [BIN-1:0]  din,
  output logic signed [COUT-1:0] dout,
  output logic                   dout_vld,
  output logic                   dout_sat
);

  typedef enum logic {WARMUP, RUN} state_t;

  localparam int NM = N * M;
  localparam int WW = $clog2(NM + 1);
  localparam logic signed [BOUT:0] MAXV = {{(BOUT+2-COUT){1'b0}}, {(COUT-1){1'b1}}};
  localparam logic signed [BOUT:0] MINV = {{(BOUT+2-COUT){1'b1}}, {(COUT-1){1'b0}}};

  // One guard bit keeps the rounding bias from wrapping a full-scale comb output.
  function automatic logic signed [BOUT:0] round_shift(input logic signed [BOUT-1:0] x,
                                                       input logic [SW-1:0]         sh);
    logic signed [BOUT:0] bias;
    logic signed [BOUT:0] sum;
    bias = '0;
    if (sh != '0) bias[sh - 1'b1] = 1'b1;
    sum = {x[BOUT-1], x} + bias;
    return sum >>> sh;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [COUT:0] saturate(input logic signed [BOUT:0] s);
    if (s > MAXV) return {1'b1, MAXV[COUT-1:0]};
    if (s < MINV) return {1'b1, MINV[COUT-1:0]};
    return {1'b0, s[COUT-1:0]};
  endfunction

  state_t                 state_q, state_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic [RW-1:0]          rate_q, rate_d;
  logic [RW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic signed [BOUT-1:0] integ_q [N];
  logic signed [BOUT-1:0] integ_d [N];
  logic signed [BOUT-1:0] dly_q [N][M];
  logic signed [BOUT-1:0] dly_d [N][M];
  logic signed [BOUT-1:0] dec_q, dec_d;
  logic                   dec_vld_q, dec_vld_d;
  logic signed [COUT-1:0] dout_q, dout_d;
  logic                   dout_vld_q, dout_vld_d;
  logic                   dout_sat_q, dout_sat_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   cfg_ok, cfg_take, accept, strobe;
  logic signed [BOUT-1:0] isum [N];
  logic signed [BOUT-1:0] cx [N+1];
  logic [COUT:0]          scaled;

  always_comb begin
    cfg_ok   = (cfg_rate >= RW'(2)) && (cfg_rate <= RW'(RMAX)) && (int'(cfg_shift) < BOUT);
    cfg_take = cfg_load && cfg_ok;
    accept   = din_vld && !cfg_take;
    strobe   = accept && (cnt_q == rate_q - 1'b1);

    // Integrator chain is combinational so the captured sum includes the current sample.
    isum[0] = integ_q[0] + {{(BOUT-BIN){din[BIN-1]}}, din};
    for (int k = 1; k < N; k++) isum[k] = integ_q[k] + isum[k-1];

    cx[0] = dec_q;
    for (int k = 0; k < N; k++) cx[k+1] = cx[k] - dly_q[k][M-1];
    scaled = saturate(round_shift(cx[N], shift_q));

    rate_d      = rate_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    integ_d     = integ_q;
    dly_d       = dly_q;
    dec_d       = dec_q;
    dec_vld_d   = 1'b0;
    dout_d      = dout_q;
    dout_sat_d  = dout_sat_q;
    cfg_err_d   = cfg_load && !cfg_ok;

    if (cfg_take) begin
      rate_d  = cfg_rate;
      shift_d = cfg_shift;
      cnt_d   = '0;
      dec_d   = '0;
      for (int k = 0; k < N; k++) begin
        integ_d[k] = '0;
        for (int j = 0; j < M; j++) dly_d[k][j] = '0;
      end
    end else begin
      if (accept) begin
        integ_d = isum;
        cnt_d   = strobe ? '0 : cnt_q + 1'b1;
      end
      if (strobe) begin
        dec_d     = isum[N-1];
        dec_vld_d = 1'b1;
      end
      // Comb stage: delay lines move only on decimated samples.
      if (dec_vld_q) begin
        for (int k = 0; k < N; k++) begin
          dly_d[k][0] = cx[k];
          for (int j = 1; j < M; j++) dly_d[k][j] = dly_q[k][j-1];
        end
        dout_d     = scaled[COUT-1:0];
        dout_sat_d = scaled[COUT];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dout_vld_d = 1'b0;
    if (cfg_take) begin
      state_d = WARMUP;
      wcnt_d  = '0;
    end else if (dec_vld_q) begin
      if (state_q == RUN) begin
        dout_vld_d = 1'b1;
      end else if (wcnt_q == WW'(NM - 1)) begin
        state_d = RUN;
        wcnt_d  = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WARMUP;
      wcnt_q     <= '0;
      rate_q     <= RW'(RMAX);
      shift_q    <= SW'(BOUT - COUT);
      cnt_q      <= '0;
      dec_q      <= '0;
      dec_vld_q  <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_sat_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rate_q     <= rate_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      dec_vld_q  <= dec_vld_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_sat_q <= dout_sat_d;
      cfg_err_q  <= cfg_err_d;
      integ_q    <= integ_d;
      dly_q      <= dly_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_sat = dout_sat_q;
  assign cfg_err  = cfg_err_q;

endmodule
